// File: rtl/axis_ingress_packetizer.sv
// ============================================================================
//  Module      : axis_ingress_packetizer
//  Description : AXI4-Stream ingress stage with a 2-entry skid buffer. It locks
//                TDEST/TID for each packet and truncates over-long packets.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_ingress_packetizer #(
    parameter int DATA_WIDTH  = 2,
    parameter int TDEST_WIDTH = 4,
    parameter int TID_WIDTH   = 2,
    parameter int TUSER_WIDTH = 2,
    parameter int MAX_PKT_LEN = 256,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH*8-1:0]  s_axis_tdata,
    input  logic [TDEST_WIDTH-1:0]   s_axis_tdest,
    input  logic [TID_WIDTH-1:0]     s_axis_tid,
    input  logic [TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic [DATA_WIDTH*8-1:0]  m_axis_tdata,
    output logic [TDEST_WIDTH-1:0]   m_axis_tdest,
    output logic [TID_WIDTH-1:0]     m_axis_tid,
    output logic [TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic [CNT_WIDTH-1:0]     pkt_count,
    output logic [CNT_WIDTH-1:0]     trunc_count,
    output logic                     trunc_pulse
);

    localparam int c_cnt_w  = $clog2(MAX_PKT_LEN + 1);
    localparam int c_beat_w = DATA_WIDTH*8 + TDEST_WIDTH + TID_WIDTH + TUSER_WIDTH + 1;
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(MAX_PKT_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IN_PKT = 2'd1,
        ST_DROP   = 2'd2
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [c_cnt_w-1:0]      r_cnt, w_cnt_nxt;
    logic [TDEST_WIDTH-1:0]  r_lock_dest, w_beat_dest;
    logic [TID_WIDTH-1:0]    r_lock_id, w_beat_id;
    logic                    w_beat_last, w_push, w_trunc, w_pkt_end, w_lock_en;
    logic [c_beat_w-1:0]     w_beat, r_out, r_skid;
    logic                    r_out_valid, r_skid_valid, r_ready;
    logic [CNT_WIDTH-1:0]    r_pkt_count, r_trunc_count;
    logic                    r_trunc_pulse;
    logic                    w_accept, w_out_free, w_skid_valid_nxt;

    assign w_accept   = s_axis_tvalid & r_ready;
    assign w_out_free = ~r_out_valid | m_axis_tready;

    // Packet framing; all transitions are qualified by an accepted input beat.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        w_trunc     = 1'b0;
        w_pkt_end   = 1'b0;
        w_lock_en   = 1'b0;
        w_beat_last = s_axis_tlast;
        w_beat_dest = r_lock_dest;
        w_beat_id   = r_lock_id;
        case (r_state)
            ST_IDLE: begin
                w_beat_dest = s_axis_tdest;
                w_beat_id   = s_axis_tid;
                if (w_accept) begin
                    w_push    = 1'b1;
                    w_lock_en = 1'b1;
                    if (s_axis_tlast) begin
                        w_pkt_end = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = ST_IN_PKT;
                        w_cnt_nxt   = c_cnt_w'(1);
                    end
                end
            end
            ST_IN_PKT: begin
                if (w_accept) begin
                    w_push = 1'b1;
                    if (s_axis_tlast) begin
                        w_pkt_end   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else if (r_cnt == c_last_idx) begin
                        w_beat_last = 1'b1;
                        w_trunc     = 1'b1;
                        w_pkt_end   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_DROP;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_w'(1);
                    end
                end
            end
            ST_DROP: begin
                if (w_accept && s_axis_tlast) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_beat = {s_axis_tdata, w_beat_dest, w_beat_id, s_axis_tuser, w_beat_last};

    // Ready only opens when the skid is empty, so a push never meets a full skid.
    assign w_skid_valid_nxt = r_skid_valid ? ~w_out_free : (w_push & ~w_out_free);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_lock_dest   <= '0;
            r_lock_id     <= '0;
            r_out         <= '0;
            r_skid        <= '0;
            r_out_valid   <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_ready       <= 1'b0;
            r_pkt_count   <= '0;
            r_trunc_count <= '0;
            r_trunc_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_ready      <= ~w_skid_valid_nxt;
            if (w_lock_en) begin
                r_lock_dest <= s_axis_tdest;
                r_lock_id   <= s_axis_tid;
            end
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out       <= r_skid;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= w_push;
                    if (w_push) begin
                        r_out <= w_beat;
                    end
                end
            end else if (w_push) begin
                r_skid <= w_beat;
            end
            if (w_pkt_end && (r_pkt_count != '1)) begin
                r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
            end
            if (w_trunc && (r_trunc_count != '1)) begin
                r_trunc_count <= r_trunc_count + CNT_WIDTH'(1);
            end
            r_trunc_pulse <= w_trunc;
        end
    end

    assign s_axis_tready = r_ready;
    assign m_axis_tvalid = r_out_valid;
    assign {m_axis_tdata, m_axis_tdest, m_axis_tid, m_axis_tuser, m_axis_tlast} = r_out;
    assign pkt_count     = r_pkt_count;
    assign trunc_count   = r_trunc_count;
    assign trunc_pulse   = r_trunc_pulse;

endmodule

`default_nettype wire

// File: tb/tb_axis_ingress_packetizer.sv
// ============================================================================
//  Module      : tb_axis_ingress_packetizer
//  Description : Scoreboard bench for axis_ingress_packetizer (MAX_PKT_LEN=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_ingress_packetizer;

    localparam int MAX_PKT_LEN = 4;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dest;
        logic [1:0]  id;
        logic [1:0]  user;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] s_axis_tdata;
    logic [3:0]  s_axis_tdest;
    logic [1:0]  s_axis_tid;
    logic [1:0]  s_axis_tuser;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [15:0] m_axis_tdata;
    logic [3:0]  m_axis_tdest;
    logic [1:0]  m_axis_tid;
    logic [1:0]  m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [15:0] pkt_count;
    logic [15:0] trunc_count;
    logic        trunc_pulse;

    axis_ingress_packetizer #(
        .DATA_WIDTH  (2),
        .TDEST_WIDTH (4),
        .TID_WIDTH   (2),
        .TUSER_WIDTH (2),
        .MAX_PKT_LEN (MAX_PKT_LEN),
        .CNT_WIDTH   (16)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tdest  (s_axis_tdest),
        .s_axis_tid    (s_axis_tid),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .pkt_count     (pkt_count),
        .trunc_count   (trunc_count),
        .trunc_pulse   (trunc_pulse)
    );

    always #5 clk = ~clk;

    beat_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_acc    = 0;
    int          n_out    = 0;
    int          n_pulse  = 0;
    int          exp_pkts  = 0;
    int          exp_trunc = 0;
    int          m_state   = 0;   // 0 idle, 1 in packet, 2 dropping
    int          m_cnt     = 0;
    logic [3:0]  lock_dest;
    logic [1:0]  lock_id;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model of the packet framing rules, applied on each accepted beat.
    task automatic model_accept(input logic [15:0] d, input logic [3:0] dest,
                                input logic [1:0] id, input logic [1:0] user, input logic last);
        beat_t b;
        n_acc++;
        b = '{data: d, dest: lock_dest, id: lock_id, user: user, last: last};
        if (m_state == 0) begin
            lock_dest = dest;
            lock_id   = id;
            b.dest = dest;
            b.id   = id;
            exp_q.push_back(b);
            if (last) exp_pkts++;
            else begin m_state = 1; m_cnt = 1; end
        end else if (m_state == 1) begin
            if (last) begin
                exp_q.push_back(b); exp_pkts++; m_state = 0; m_cnt = 0;
            end else if (m_cnt == MAX_PKT_LEN - 1) begin
                b.last = 1'b1;
                exp_q.push_back(b); exp_pkts++; exp_trunc++; m_state = 2; m_cnt = 0;
            end else begin
                exp_q.push_back(b); m_cnt++;
            end
        end else if (last) begin
            m_state = 0;
        end
    endtask

    task automatic send_beat(input logic [15:0] d, input logic [3:0] dest,
                             input logic [1:0] id, input logic [1:0] user, input logic last);
        logic w;
        logic acc = 1'b0;
        @(negedge clk); #1;
        s_axis_tdata = d; s_axis_tdest = dest; s_axis_tid = id;
        s_axis_tuser = user; s_axis_tlast = last; s_axis_tvalid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            w = s_axis_tready & ~rst;
            @(posedge clk);
            if (w) begin acc = 1'b1; break; end
            @(negedge clk); #1;
        end
        if (acc) model_accept(d, dest, id, user, last);
        else check_eq("accept_timeout", 32'd0, 32'd1);
        #1 s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [15:0] base, input logic [3:0] dest,
                            input logic [1:0] id, input bit vary);
        for (int i = 0; i < n; i++) begin
            send_beat(base + 16'(i), vary ? 4'(dest + 4*i) : dest,
                      vary ? 2'(id + i) : id, 2'(i), (i == n-1));
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && t < 300) begin
            @(posedge clk); #1; t++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (trunc_pulse) n_pulse++;
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            n_out++;
            if (exp_q.size() == 0) check_eq("unexpected_beat", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check_eq("tdata", 32'(m_axis_tdata), 32'(e.data));
                check_eq("tdest", 32'(m_axis_tdest), 32'(e.dest));
                check_eq("tid",   32'(m_axis_tid),   32'(e.id));
                check_eq("tuser", 32'(m_axis_tuser), 32'(e.user));
                check_eq("tlast", 32'(m_axis_tlast), 32'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a0, n0;
        rst = 1'b1; m_axis_tready = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        s_axis_tdata = '0; s_axis_tdest = '0; s_axis_tid = '0; s_axis_tuser = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_sready", 32'(s_axis_tready), 32'd0);
        check_eq("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
        check_eq("rst_mdata",  32'(m_axis_tdata),  32'd0);
        check_eq("rst_pkts",   32'(pkt_count),     32'd0);
        check_eq("rst_trunc",  32'(trunc_count),   32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst_sready", 32'(s_axis_tready), 32'd1);
        m_axis_tready = 1'b1;

        // single-beat packet, one-cycle latency
        send_beat(16'hA5A5, 4'hC, 2'd1, 2'd2, 1'b1);
        check_eq("lat_mvalid", 32'(m_axis_tvalid), 32'd1);
        check_eq("lat_tdest",  32'(m_axis_tdest),  32'hC);
        check_eq("lat_tlast",  32'(m_axis_tlast),  32'd1);
        drain();
        check_eq("pkts_1beat", 32'(pkt_count), 32'(exp_pkts));

        // tdest/tid vary per beat; output must stay locked
        send_pkt(4, 16'h1000, 4'h4, 2'd0, 1'b1);
        drain();
        check_eq("pkts_lock", 32'(pkt_count), 32'(exp_pkts));

        // back-pressure: output stalled for 5 cycles
        #1 m_axis_tready = 1'b0;
        a0 = n_acc;
        fork
            begin
                send_pkt(3, 16'h2000, 4'h6, 2'd1, 1'b0);
                send_pkt(3, 16'h3000, 4'h7, 2'd2, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                check_eq("bp_held",   32'(n_acc - a0), 32'd2);
                check_eq("bp_sready", 32'(s_axis_tready), 32'd0);
                #1 m_axis_tready = 1'b1;
                n0 = n_out;
                repeat (4) @(posedge clk);
                #1 check_eq("bp_throughput", 32'(n_out - n0), 32'd4);
            end
        join
        drain();
        check_eq("pkts_bp", 32'(pkt_count), 32'(exp_pkts));

        // truncation of a 7-beat packet, then a fresh packet with its own tdest
        n_pulse = 0;
        send_pkt(7, 16'h4000, 4'h9, 2'd3, 1'b0);
        send_pkt(1, 16'h5000, 4'hB, 2'd0, 1'b0);
        drain();
        check_eq("trunc_count", 32'(trunc_count), 32'(exp_trunc));
        check_eq("trunc_pulse_cycles", 32'(n_pulse), 32'd1);
        check_eq("pkts_trunc", 32'(pkt_count), 32'(exp_pkts));

        // exactly MAX_PKT_LEN beats with natural tlast
        send_pkt(4, 16'h6000, 4'h2, 2'd1, 1'b1);
        drain();
        check_eq("exact_trunc", 32'(trunc_count), 32'(exp_trunc));
        check_eq("exact_pkts",  32'(pkt_count),   32'(exp_pkts));

        // reset in the middle of a packet with two beats buffered
        #1 m_axis_tready = 1'b0;
        send_beat(16'h8000, 4'h5, 2'd1, 2'd0, 1'b0);
        send_beat(16'h8001, 4'h6, 2'd2, 2'd1, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        m_state = 0; m_cnt = 0; exp_pkts = 0; exp_trunc = 0;
        @(posedge clk); #1;
        check_eq("midrst_mvalid", 32'(m_axis_tvalid), 32'd0);
        check_eq("midrst_pkts",   32'(pkt_count),     32'd0);
        check_eq("midrst_trunc",  32'(trunc_count),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_axis_tready = 1'b1;
        send_pkt(2, 16'h7000, 4'hE, 2'd2, 1'b1);
        drain();
        check_eq("postrst_pkts", 32'(pkt_count), 32'(exp_pkts));
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
